req_arbiter: RTL and testbench
==============================

Name: req_arbiter

Overview:
- 16-requester arbiter for a shared resource, with requests presented as two 8-bit buses concatenated {req_a, req_b}.
- Bit 15 (req_a[7]) is the highest fixed priority; bit 0 (req_b[0]) is the lowest.
- Grants one requester at a time, holds the grant until the requester releases it or a hold timeout fires, and optionally rotates priority round-robin.
- Sits between requesting units and the shared resource; grant_id drives the resource select.

Parameters:
- CNT_W, 4, width of the hold counter.
- HOLD_MAX, 15, maximum cycles a grant may be held before forced release; 0 disables the timeout; must be < 2^CNT_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ena  input  1  arbiter enable; low blocks new grants and forces release.
- req_a  input  8  requests 15..8 (req_a[i] is requester i+8).
- req_b  input  8  requests 7..0.
- rr_mode  input  1  0 = fixed priority, 1 = round-robin.
- done  input  1  current grant holder releases the resource.
- grant_valid  output  1  a grant is active.
- grant_id  output  4  index of the granted requester; holds its last value when grant_valid=0.
- grant_onehot  output  16  one-hot of grant_id while grant_valid=1; all zeros otherwise.
- timeout  output  1  single-cycle pulse after a forced release.

Behaviour:
- Reset (async assert, sync release): state=IDLE, grant_valid=0, grant_id=0, grant_onehot=0, timeout=0, hold_cnt=0, last_id=0.
- req[15:0] = {req_a, req_b}. All outputs are registered.
- State machine has two states: IDLE and GRANT.
- IDLE, with ena=1 and req!=0 at an edge:
  - Winner selected combinationally from req and rr_mode sampled at that edge.
  - Next state GRANT; grant_valid=1, grant_id=winner, grant_onehot=1<<winner, hold_cnt=1.
  - Latency: a request present at edge N in IDLE is granted from edge N.
- IDLE, with ena=0 or req=0: stay in IDLE, outputs unchanged except timeout=0.
- Winner, fixed mode (rr_mode=0): highest set bit of req.
- Winner, round-robin mode (rr_mode=1):
  - First set bit searched downward from (last_id-1) mod 16, wrapping 0 -> 15.
  - last_id=0 after reset, so the first RR search starts at 15 and matches fixed priority.
  - If only last_id is requesting, it wins again.
- GRANT, evaluated at each edge in this order:
  1. Normal release: done=1, or req[grant_id]=0, or ena=0 -> IDLE; grant_valid=0, grant_onehot=0, last_id=grant_id, timeout=0.
  2. Timeout release: otherwise, if HOLD_MAX!=0 and hold_cnt==HOLD_MAX -> IDLE as above, timeout=1 for exactly the next cycle.
  3. Otherwise: stay in GRANT, hold_cnt increments (saturating at 2^CNT_W-1).
- Normal release takes precedence over timeout when both occur at the same edge: no timeout pulse.
- Every release is followed by at least one full cycle with grant_valid=0 (the IDLE cycle), so requesters can observe the release.
- A grant is therefore held for at most HOLD_MAX cycles with grant_valid=1.
- rr_mode changes take effect only at the next arbitration in IDLE; the current grant is never preempted by higher-priority requests.
- last_id updates only on release, including timeout release. A timed-out requester drops to lowest priority in RR mode.
- timeout returns to 0 on the edge after its pulse.
- Reset asserted mid-grant clears all outputs immediately, without waiting for a clock edge.

Test Plan:
- Reset mid-grant: grant active on id 9, drop rst_n between edges -> grant_valid, grant_onehot, timeout go 0 immediately; grant_id=0; after release, first grant follows the normal one-cycle latency.
- Fixed priority: rr_mode=0, req_a=0x00, req_b=0x24 held, done pulsed 1 cycle every 3rd grant cycle -> grant_id=5, onehot=0x0020, one idle cycle after each done, then id 5 again; id 2 is never granted.
- Round-robin: rr_mode=1, req_a=0x80, req_b=0x01 held, done pulsed each grant -> grant_id sequence 15, 0, 15, 0, with one idle cycle between grants.
- Timeout: HOLD_MAX=4, only req_a[1] (id 9) held, done=0 -> grant_valid high exactly 4 cycles, timeout=1 for one cycle, grant_valid=0 for one cycle, then id 9 re-granted.
- Collision: HOLD_MAX=4, done=1 on the 4th grant cycle -> release with timeout staying 0.
- Enable: ena dropped during a grant on id 3 -> grant_valid=0 at the next edge, no timeout pulse, no grants while ena=0 with req=0xFFFF; ena=1 -> grant on id 15 (fixed mode) at the next edge.

Source files
------------

// File: rtl/req_arbiter.sv
// req_arbiter: 16-way arbiter for a shared resource.
// Requests arrive as {req_a, req_b}; bit 15 is the highest fixed priority.
// A grant is held until the owner signals done, drops its request, the
// arbiter is disabled, or the hold timeout fires. Optional round-robin
// rotation searches downward from just below the last released owner.
module req_arbiter #(
  parameter int CNT_W    = 4,
  parameter int HOLD_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic [7:0]  req_a,
  input  logic [7:0]  req_b,
  input  logic        rr_mode,
  input  logic        done,
  output logic        grant_valid,
  output logic [3:0]  grant_id,
  output logic [15:0] grant_onehot,
  output logic        timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   hold_cnt, hold_cnt_nx;
  logic [3:0]         last_id, last_id_nx;
  logic               grant_valid_nx;
  logic [3:0]         grant_id_nx;
  logic [15:0]        grant_onehot_nx;
  logic               timeout_nx;

  logic [15:0]        req;
  logic [3:0]         fix_id;
  logic [3:0]         rr_id;
  logic [3:0]         rr_idx;
  logic [3:0]         winner;
  logic               rel_norm;
  logic               rel_to;

  assign req = {req_a, req_b};

  // Hold counter increments but never wraps back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Pick the fixed-priority and round-robin candidates from the live requests.
  always_comb begin
    fix_id = 4'd0;
    rr_id  = 4'd0;
    rr_idx = 4'd0;
    // Ascending scan: the last hit is the highest set bit.
    for (int i = 0; i < 16; i++) begin
      if (req[i]) fix_id = 4'(i);
    end
    // Scan from farthest (last_id itself) to nearest (last_id-1) so the
    // nearest requester below last_id overwrites the others.
    for (int k = 16; k >= 1; k--) begin
      rr_idx = last_id - 4'(k);
      if (req[rr_idx]) rr_id = rr_idx;
    end
    winner = rr_mode ? rr_id : fix_id;
  end

  // Next-state and registered-output values for the IDLE/GRANT machine.
  always_comb begin
    state_nx        = state;
    grant_valid_nx  = grant_valid;
    grant_id_nx     = grant_id;
    grant_onehot_nx = grant_onehot;
    timeout_nx      = 1'b0;
    hold_cnt_nx     = hold_cnt;
    last_id_nx      = last_id;
    rel_norm        = done || !req[grant_id] || !ena;
    rel_to          = (HOLD_MAX != 0) && (hold_cnt == CNT_W'(HOLD_MAX));
    case (state)
      IDLE: begin
        if (ena && (req != 16'd0)) begin
          state_nx        = GRANT;
          grant_valid_nx  = 1'b1;
          grant_id_nx     = winner;
          grant_onehot_nx = 16'd1 << winner;
          hold_cnt_nx     = CNT_W'(1);
        end
      end
      GRANT: begin
        if (rel_norm || rel_to) begin
          // A normal release at the same edge as the timeout suppresses the pulse.
          state_nx        = IDLE;
          grant_valid_nx  = 1'b0;
          grant_onehot_nx = 16'd0;
          last_id_nx      = grant_id;
          timeout_nx      = !rel_norm;
        end else begin
          hold_cnt_nx = sat_inc(hold_cnt);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      grant_valid  <= 1'b0;
      grant_id     <= 4'd0;
      grant_onehot <= 16'd0;
      timeout      <= 1'b0;
      hold_cnt     <= '0;
      last_id      <= 4'd0;
    end else begin
      state        <= state_nx;
      grant_valid  <= grant_valid_nx;
      grant_id     <= grant_id_nx;
      grant_onehot <= grant_onehot_nx;
      timeout      <= timeout_nx;
      hold_cnt     <= hold_cnt_nx;
      last_id      <= last_id_nx;
    end
  end

endmodule

// File: tb/tb_req_arbiter.sv
// tb_req_arbiter: scoreboard bench for req_arbiter with a 4-cycle hold limit.
module tb_req_arbiter;

  localparam int CNT_W    = 4;
  localparam int HOLD_MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic [7:0]  req_a = 8'h00;
  logic [7:0]  req_b = 8'h00;
  logic        rr_mode = 1'b0;
  logic        done = 1'b0;
  logic        grant_valid;
  logic [3:0]  grant_id;
  logic [15:0] grant_onehot;
  logic        timeout;

  req_arbiter #(.CNT_W(CNT_W), .HOLD_MAX(HOLD_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .req_a(req_a), .req_b(req_b),
    .rr_mode(rr_mode), .done(done), .grant_valid(grant_valid),
    .grant_id(grant_id), .grant_onehot(grant_onehot), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nfail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural reference model.
  bit         m_busy, m_gv, m_to;
  logic [3:0] m_gid, m_last;
  int         m_cnt;

  typedef struct {
    logic        gv;
    logic [3:0]  gid;
    logic [15:0] oh;
    logic        to;
  } exp_t;
  exp_t sbq[$];

  task automatic m_reset();
    m_busy = 0; m_gv = 0; m_to = 0; m_gid = 4'd0; m_last = 4'd0; m_cnt = 0;
  endtask

  function automatic int pick(input logic [15:0] r, input bit rr, input logic [3:0] last);
    int w;
    w = -1;
    if (!rr) begin
      for (int i = 15; i >= 0; i--) if (r[i] && w < 0) w = i;
    end else begin
      for (int k = 1; k <= 16; k++) begin
        int idx;
        idx = (int'(last) - k + 32) % 16;
        if (r[idx] && w < 0) w = idx;
      end
    end
    return w;
  endfunction

  task automatic model_step();
    logic [15:0] r;
    r = {req_a, req_b};
    if (!m_busy) begin
      m_to = 0;
      if (ena && r != 16'd0) begin
        m_busy = 1; m_gv = 1; m_cnt = 1;
        m_gid = 4'(pick(r, rr_mode, m_last));
      end
    end else if (done || !r[m_gid] || !ena) begin
      m_busy = 0; m_gv = 0; m_last = m_gid; m_to = 0;
    end else if (HOLD_MAX != 0 && m_cnt == HOLD_MAX) begin
      m_busy = 0; m_gv = 0; m_last = m_gid; m_to = 1;
    end else begin
      m_cnt = (m_cnt < (1 << CNT_W) - 1) ? m_cnt + 1 : m_cnt;
      m_to = 0;
    end
  endtask

  task automatic sb_push();
    exp_t e;
    e.gv  = m_gv;
    e.gid = m_gid;
    e.oh  = m_gv ? (16'd1 << m_gid) : 16'd0;
    e.to  = m_to;
    sbq.push_back(e);
  endtask

  task automatic sb_cmp(input string tag);
    exp_t e;
    check({tag, ".sbq"}, 32'(sbq.size() > 0), 32'd1);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check({tag, ".gv"}, 32'(grant_valid), 32'(e.gv));
      check({tag, ".id"}, 32'(grant_id), 32'(e.gid));
      check({tag, ".oh"}, 32'(grant_onehot), 32'(e.oh));
      check({tag, ".to"}, 32'(timeout), 32'(e.to));
    end
  endtask

  task automatic step(input string tag);
    model_step();
    sb_push();
    @(posedge clk);
    #1;
    sb_cmp(tag);
  endtask

  task automatic async_reset(input string tag);
    #1 rst_n = 1'b0;
    #1 m_reset();
    sb_push();
    sb_cmp(tag);
    #1 rst_n = 1'b1;
  endtask

  int n2, ng, npulse, run, ngv;
  bit prev_gv, seen_fall;
  logic [3:0] ids[$];
  int rr_exp[4] = '{15, 0, 15, 0};

  initial begin
    m_reset();
    #2;
    sb_push();
    sb_cmp("reset");
    #1 rst_n = 1'b1;

    // Reset mid-grant on id 9, then normal one-edge grant latency.
    ena = 1'b1; req_a = 8'h02;
    step("pre_rst0");
    step("pre_rst1");
    check("pre_rst_id", 32'(grant_id), 32'd9);
    async_reset("rst_mid");
    step("post_rst");
    check("post_rst_gv", 32'(grant_valid), 32'd1);
    check("post_rst_id", 32'(grant_id), 32'd9);
    req_a = 8'h00;
    step("idle0");

    // Fixed priority: ids 5 and 2, done on every third grant cycle.
    rr_mode = 1'b0; req_a = 8'h00; req_b = 8'h24;
    n2 = 0; ng = 0; prev_gv = 0;
    for (int i = 0; i < 12; i++) begin
      done = m_gv && m_cnt == 3;
      step("fixed");
      if (grant_valid && grant_id == 4'd2) n2++;
      if (grant_valid && !prev_gv) ng++;
      prev_gv = grant_valid;
    end
    done = 1'b0;
    check("fixed_no_id2", 32'(n2), 32'd0);
    check("fixed_ngrants", 32'(ng), 32'd3);

    // Round-robin between ids 15 and 0, starting from a fresh last_id.
    req_b = 8'h00;
    step("idle1");
    async_reset("rst_rr");
    rr_mode = 1'b1; req_a = 8'h80; req_b = 8'h01;
    prev_gv = 0;
    ids.delete();
    for (int i = 0; i < 9; i++) begin
      done = m_gv;
      step("rr");
      if (grant_valid && !prev_gv) ids.push_back(grant_id);
      prev_gv = grant_valid;
    end
    done = 1'b0;
    check("rr_count", 32'(ids.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (i < ids.size()) check($sformatf("rr_seq%0d", i), 32'(ids[i]), 32'(rr_exp[i]));
    end

    // Timeout: id 9 alone, never done.
    rr_mode = 1'b0; req_a = 8'h00; req_b = 8'h00;
    step("idle2");
    req_a = 8'h02;
    run = 0; seen_fall = 0; prev_gv = 0;
    for (int i = 0; i < 10; i++) begin
      step("tmo");
      if (grant_valid) run++;
      else if (prev_gv && !seen_fall) begin
        seen_fall = 1;
        check("tmo_len", 32'(run), 32'd4);
        check("tmo_pulse", 32'(timeout), 32'd1);
      end
      prev_gv = grant_valid;
    end
    check("tmo_seen", 32'(seen_fall), 32'd1);

    // Collision: done on the fourth grant cycle wins over the timeout.
    npulse = 0;
    for (int i = 0; i < 12; i++) begin
      done = m_gv && m_cnt == 4;
      step("coll");
      if (timeout) npulse++;
    end
    done = 1'b0;
    check("coll_no_pulse", 32'(npulse), 32'd0);

    // Enable: drop during a grant on id 3, no grants while disabled.
    req_a = 8'h00; req_b = 8'h00;
    step("idle3");
    req_b = 8'h08;
    step("ena_g0");
    check("ena_g_id", 32'(grant_id), 32'd3);
    step("ena_g1");
    ena = 1'b0; req_a = 8'hFF; req_b = 8'hFF;
    step("ena_off");
    check("ena_off_gv", 32'(grant_valid), 32'd0);
    check("ena_off_to", 32'(timeout), 32'd0);
    ngv = 0;
    for (int i = 0; i < 3; i++) begin
      step("ena_hold");
      if (grant_valid) ngv++;
    end
    check("ena_hold_gv", 32'(ngv), 32'd0);
    ena = 1'b1;
    step("ena_on");
    check("ena_on_gv", 32'(grant_valid), 32'd1);
    check("ena_on_id", 32'(grant_id), 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
